// File: rtl/next_pc_unit.sv
// Next-PC sequencer: a four-state fetch/execute controller that registers the
// next program address, a one-cycle PC load strobe and a sticky halt flag.
module next_pc_unit #(
   parameter int unsigned MSB_ROM = 11,
   parameter int unsigned LSB     = 0
) (
   input  logic                   clock_i,
   input  logic                   reset_i,
   input  logic                   run_i,
   input  logic [MSB_ROM-1:LSB]   pc_i,
   input  logic [15:0]            instr_i,
   input  logic                   flags_update_i,
   input  logic                   z_i,
   input  logic                   n_i,
   output logic [MSB_ROM-1:LSB]   mux_o,
   output logic                   pc_en_o,
   output logic                   halted_o
);

   localparam int unsigned AW = MSB_ROM - LSB;

   localparam logic [4:0] OP_HLT = 5'b00000;
   localparam logic [4:0] OP_BEQ = 5'b01000;
   localparam logic [4:0] OP_BNE = 5'b01001;
   localparam logic [4:0] OP_BGT = 5'b01010;
   localparam logic [4:0] OP_BGE = 5'b01011;
   localparam logic [4:0] OP_BLT = 5'b01100;
   localparam logic [4:0] OP_BLE = 5'b01101;
   localparam logic [4:0] OP_JMP = 5'b01110;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic                 z_q;
   logic                 n_q;
   logic                 z_d;
   logic                 n_d;
   logic [MSB_ROM-1:LSB] mux_d;
   logic                 pc_en_d;
   logic                 halted_d;
   logic [4:0]           opcode;
   logic [10:0]          operand;
   logic                 taken;

   assign opcode  = instr_i[15:11];
   assign operand = instr_i[10:0];

   // Branch resolution against the flags registered by an earlier instruction.
   always_comb begin
      taken = 1'b0;
      unique case (opcode)
         OP_JMP:  taken = 1'b1;
         OP_BEQ:  taken = z_q;
         OP_BNE:  taken = !z_q;
         OP_BGT:  taken = !z_q && !n_q;
         OP_BGE:  taken = !n_q;
         OP_BLT:  taken = n_q;
         OP_BLE:  taken = n_q || z_q;
         default: taken = 1'b0;
      endcase
   end

   // Next-state and next-output decode; every register holds unless overridden.
   always_comb begin
      state_d  = state_q;
      mux_d    = mux_o;
      pc_en_d  = 1'b0;
      halted_d = halted_o;
      z_d      = z_q;
      n_d      = n_q;

      unique case (state_q)
         IDLE: begin
            if (run_i) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (opcode == OP_HLT) begin
               state_d  = HALT;
               halted_d = 1'b1;
            end else begin
               state_d = EXEC;
               pc_en_d = 1'b1;
               if (taken) begin
                  mux_d = AW'(operand);
               end else begin
                  // Natural wrap at the address width; no carry out is kept.
                  mux_d = pc_i + AW'(1);
               end
            end
         end
         EXEC: begin
            if (flags_update_i) begin
               z_d = z_i;
               n_d = n_i;
            end
            state_d = run_i ? FETCH : IDLE;
         end
         HALT: begin
            state_d  = HALT;
            halted_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Output and flag registers; async reset also kills an in-flight PC load.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         mux_o    <= '0;
         pc_en_o  <= 1'b0;
         halted_o <= 1'b0;
         z_q      <= 1'b0;
         n_q      <= 1'b0;
      end else begin
         mux_o    <= mux_d;
         pc_en_o  <= pc_en_d;
         halted_o <= halted_d;
         z_q      <= z_d;
         n_q      <= n_d;
      end
   end

endmodule
